// File: rtl/sram_controller.sv
// Multi-cycle bridge from the MEM-stage data port to a 16-bit asynchronous SRAM.
// Each 32-bit access is split into a low-half and a high-half phase, followed by wait phases.
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned SRAM_AW       = 18,
    parameter int unsigned ACCESS_CYCLES = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    // state    | meaning
    // ST_IDLE  | waiting for rd_en/wr_en; ready follows the request inputs
    // ST_BUSY  | SRAM access; cnt 0 = low half, 1 = high half, 2.. = wait
    // ST_DONE  | one-cycle completion, ready high, request inputs ignored
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0]  CNT_LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        op_wr_q, op_wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] offset;
    logic        half;
    logic        unused_offset_bits;

    // Byte offset into SRAM space; bits [SRAM_AW:2] give the word index, so upper bits wrap.
    assign offset             = addr_q - BASE;
    assign half               = (cnt_q != 4'd0);
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_wr_d     = op_wr_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = !(rd_en || wr_en);
                if (rd_en || wr_en) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    op_wr_d = wr_en && !rd_en;
                    cnt_d   = 4'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                sram_addr = {offset[SRAM_AW:2], half};
                if (cnt_q < 4'd2) begin
                    if (op_wr_q) begin
                        sram_we_n   = 1'b0;
                        sram_dq_oe  = 1'b1;
                        sram_dq_out = half ? wdata_q[31:16] : wdata_q[15:0];
                    end else if (half) begin
                        rdata_d[31:16] = sram_dq_in;
                    end else begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            op_wr_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
        end
    end

    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with behavioural asynchronous SRAM models.
// A second instance runs with ACCESS_CYCLES = 2 on a small SRAM.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_dq_oe;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        rd2, wr2;
    logic [31:0] addr2, wd2, read_data2;
    logic        ready2;
    logic [3:0]  sram_addr2;
    logic        sram_we_n2, sram_dq_oe2;
    logic [15:0] sram_dq_out2, sram_dq_in2;

    logic [15:0] mem  [0:(1<<18)-1];
    logic [15:0] mem2 [0:15];

    int checks = 0;
    int errors = 0;

    logic [17:0] tr_addr [0:31];
    logic        tr_we   [0:31];
    logic        tr_oe   [0:31];
    logic [15:0] tr_dq   [0:31];
    int          lat;
    logic [31:0] rd_at_done;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    sram_controller #(.BASE_ADDR(1024), .SRAM_AW(4), .ACCESS_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .rd_en(rd2), .wr_en(wr2), .address(addr2),
        .write_data(wd2), .read_data(read_data2), .ready(ready2),
        .sram_addr(sram_addr2), .sram_we_n(sram_we_n2), .sram_dq_out(sram_dq_out2),
        .sram_dq_oe(sram_dq_oe2), .sram_dq_in(sram_dq_in2)
    );

    // Asynchronous SRAM: combinational read, write committed while we_n is low at the edge.
    assign sram_dq_in  = mem[sram_addr];
    assign sram_dq_in2 = mem2[sram_addr2];

    always @(posedge clk) begin
        if (!sram_we_n)  mem[sram_addr]   <= sram_dq_out;
        if (!sram_we_n2) mem2[sram_addr2] <= sram_dq_out2;
    end

    // Drives a request at the current negedge, holds it until ready, records the bus per cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd);
        int n;
        rd_en = rd; wr_en = wr; address = a; write_data = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            tr_addr[n] = sram_addr;
            tr_we[n]   = sram_we_n;
            tr_oe[n]   = sram_dq_oe;
            tr_dq[n]   = sram_dq_out;
        end while (!ready && n < 20);
        lat = ready ? n : -1;
        rd_at_done = read_data;
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wd2 = '0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b exp 1", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", sram_dq_oe); end
        checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", sram_addr); end
        checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL reset_dq got %h exp 0", sram_dq_out); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", read_data); end
        rd_en = 1'b1; #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready_req got %b exp 0", ready); end
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write();
        int we_lo;
        int oe_bad;
        run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        checks++; if (lat !== 6) begin errors++; $display("FAIL write_latency got %0d exp 6", lat); end
        checks++; if (tr_addr[1] !== 18'd0 || tr_dq[1] !== 16'hBEEF || tr_we[1] !== 1'b0)
            begin errors++; $display("FAIL write_ph0 got addr %0d dq %h we %b exp 0 BEEF 0", tr_addr[1], tr_dq[1], tr_we[1]); end
        checks++; if (tr_addr[2] !== 18'd1 || tr_dq[2] !== 16'hDEAD || tr_we[2] !== 1'b0)
            begin errors++; $display("FAIL write_ph1 got addr %0d dq %h we %b exp 1 DEAD 0", tr_addr[2], tr_dq[2], tr_we[2]); end
        checks++; if (tr_addr[3] !== 18'd1 || tr_we[3] !== 1'b1)
            begin errors++; $display("FAIL write_wait got addr %0d we %b exp 1 1", tr_addr[3], tr_we[3]); end
        we_lo = 0; oe_bad = 0;
        for (int i = 1; i <= 6; i++) begin
            if (tr_we[i] === 1'b0) we_lo++;
            if (tr_oe[i] !== !tr_we[i]) oe_bad++;
        end
        checks++; if (we_lo !== 2) begin errors++; $display("FAIL write_pulses got %0d exp 2", we_lo); end
        checks++; if (oe_bad !== 0) begin errors++; $display("FAIL write_oe_match got %0d bad cycles exp 0", oe_bad); end
        checks++; if (tr_addr[6] !== 18'd0 || tr_dq[6] !== 16'h0)
            begin errors++; $display("FAIL write_done_bus got addr %0d dq %h exp 0 0", tr_addr[6], tr_dq[6]); end
        checks++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD)
            begin errors++; $display("FAIL write_mem got %h %h exp BEEF DEAD", mem[0], mem[1]); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL write_rdata_hold got %h exp 0", read_data); end
    endtask

    task automatic test_read();
        run_access(1'b1, 1'b0, 32'd1024, 32'h0);
        checks++; if (lat !== 6) begin errors++; $display("FAIL read_latency got %0d exp 6", lat); end
        checks++; if (rd_at_done !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h exp DEADBEEF", rd_at_done); end
        checks++; if (tr_we[1] !== 1'b1 || tr_oe[2] !== 1'b0)
            begin errors++; $display("FAIL read_no_strobe got we %b oe %b exp 1 0", tr_we[1], tr_oe[2]); end
    endtask

    task automatic test_addr_map();
        run_access(1'b1, 1'b0, 32'd1028, 32'h0);
        checks++; if (tr_addr[1] !== 18'd2 || tr_addr[2] !== 18'd3)
            begin errors++; $display("FAIL map_1028 got %0d %0d exp 2 3", tr_addr[1], tr_addr[2]); end
        checks++; if (rd_at_done !== 32'h22221111) begin errors++; $display("FAIL map_1028_data got %h exp 22221111", rd_at_done); end
        run_access(1'b1, 1'b0, 32'd1024 + 32'd524288, 32'h0);
        checks++; if (tr_addr[1] !== 18'd0 || tr_addr[2] !== 18'd1)
            begin errors++; $display("FAIL map_wrap got %0d %0d exp 0 1", tr_addr[1], tr_addr[2]); end
        checks++; if (rd_at_done !== 32'hDEADBEEF) begin errors++; $display("FAIL map_wrap_data got %h exp DEADBEEF", rd_at_done); end
    endtask

    task automatic test_back_to_back();
        int first, second, highs, guard;
        logic [31:0] r1, r2;
        logic [17:0] a8;
        first = -1; second = -1; highs = 0; r1 = '0; r2 = '0; a8 = '0;
        rd_en = 1'b1; address = 32'd1024;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 8) a8 = sram_addr;
            if (ready) begin
                highs++;
                if (first < 0) begin first = c; r1 = read_data; address = 32'd1032; end
                else begin second = c; r2 = read_data; end
            end
        end
        rd_en = 1'b0;
        guard = 0;
        while (!ready && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        checks++; if (first !== 6) begin errors++; $display("FAIL b2b_first got %0d exp 6", first); end
        checks++; if (second !== 13) begin errors++; $display("FAIL b2b_second got %0d exp 13", second); end
        checks++; if (highs !== 2) begin errors++; $display("FAIL b2b_ready_count got %0d exp 2", highs); end
        checks++; if (a8 !== 18'd4) begin errors++; $display("FAIL b2b_addr got %0d exp 4", a8); end
        checks++; if (r1 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_data1 got %h exp DEADBEEF", r1); end
        checks++; if (r2 !== 32'hBBBBAAAA) begin errors++; $display("FAIL b2b_data2 got %h exp BBBBAAAA", r2); end
    endtask

    task automatic test_both();
        int we_lo, oe_hi;
        run_access(1'b1, 1'b1, 32'd1040, 32'hFFFFFFFF);
        we_lo = 0; oe_hi = 0;
        for (int i = 1; i <= 6; i++) begin
            if (tr_we[i] === 1'b0) we_lo++;
            if (tr_oe[i] === 1'b1) oe_hi++;
        end
        checks++; if (we_lo !== 0 || oe_hi !== 0)
            begin errors++; $display("FAIL both_no_write got we_lo %0d oe_hi %0d exp 0 0", we_lo, oe_hi); end
        checks++; if (rd_at_done !== 32'h12345678) begin errors++; $display("FAIL both_data got %h exp 12345678", rd_at_done); end
        checks++; if (mem[8] !== 16'h5678 || mem[9] !== 16'h1234)
            begin errors++; $display("FAIL both_mem got %h %h exp 5678 1234", mem[8], mem[9]); end
    endtask

    task automatic test_reset_mid_write();
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1024; write_data = 32'h11223344;
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL rstmid_ph0_we got %b exp 0", sram_we_n); end
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)
            begin errors++; $display("FAIL rstmid_idle got ready %b we %b oe %b exp 1 1 0", ready, sram_we_n, sram_dq_oe); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", read_data); end
        rst = 1'b0;
        run_access(1'b1, 1'b0, 32'd1024, 32'h0);
        checks++; if (rd_at_done !== 32'hDEAD3344) begin errors++; $display("FAIL rstmid_readback got %h exp DEAD3344", rd_at_done); end
    endtask

    task automatic test_short_cycles();
        int n;
        rd2 = 1'b0; wr2 = 1'b1; addr2 = 32'd1028; wd2 = 32'hCAFEF00D;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready2 && n < 10);
        wr2 = 1'b0; @(negedge clk);
        checks++; if (n !== 3) begin errors++; $display("FAIL short_write_latency got %0d exp 3", n); end
        checks++; if (mem2[2] !== 16'hF00D || mem2[3] !== 16'hCAFE)
            begin errors++; $display("FAIL short_mem got %h %h exp F00D CAFE", mem2[2], mem2[3]); end
        rd2 = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!ready2 && n < 10);
        checks++; if (n !== 3) begin errors++; $display("FAIL short_read_latency got %0d exp 3", n); end
        checks++; if (read_data2 !== 32'hCAFEF00D) begin errors++; $display("FAIL short_read_data got %h exp CAFEF00D", read_data2); end
        rd2 = 1'b0; @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem2[i] = 16'h0;
        mem[0] = 16'h0; mem[1] = 16'h0;
        mem[2] = 16'h1111; mem[3] = 16'h2222;
        mem[4] = 16'hAAAA; mem[5] = 16'hBBBB;
        mem[8] = 16'h5678; mem[9] = 16'h1234;
        test_reset();
        test_write();
        test_read();
        test_addr_map();
        test_back_to_back();
        test_both();
        test_reset_mid_write();
        test_short_cycles();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
